// File: rtl/cicero_window_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : cicero_window_pkg                                            |
// | Description : Shared types for the sliding character window feeder:       |
// |               controller state encoding and per-slot status flags.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package cicero_window_pkg;

  // Controller states of the window feeder.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Status bits kept alongside each window slot. The character payload is
  // parameterised, so it is attached to these flags inside the feeder.
  typedef struct packed {
    logic enable;    // slot holds a live character
    logic end_of_s;  // slot holds the final character of the string
    logic settled;   // slot has been live for at least one full cycle
  } slot_flags_t;

endpackage : cicero_window_pkg
`default_nettype wire

// File: rtl/char_window_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : char_window_feeder                                           |
// | Description : Feeds a circular window of 2**CC_ID_BITS character slots to  |
// |               the coprocessor topology, injects a start PC per new         |
// |               character, retires the oldest character once no engine uses |
// |               it, and reports string completion / match.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module char_window_feeder
  import cicero_window_pkg::*;
#(
  parameter int                  CHARACTER_WIDTH = 8,
  parameter int                  CC_ID_BITS      = 1,
  parameter int                  PC_WIDTH        = 8,
  parameter logic [PC_WIDTH-1:0] START_PC        = '0
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         start_i,
  input  logic [CHARACTER_WIDTH-1:0]                   in_char_i,
  input  logic                                         in_valid_i,
  output logic                                         in_ready_o,
  input  logic                                         in_last_i,
  output logic [(2**CC_ID_BITS)*CHARACTER_WIDTH-1:0]   cur_window_o,
  output logic [(2**CC_ID_BITS)-1:0]                   cur_window_enable_o,
  output logic [(2**CC_ID_BITS)-1:0]                   cur_window_end_of_s_o,
  output logic                                         new_char_o,
  input  logic [(2**CC_ID_BITS)-1:0]                   elaborating_chars_i,
  input  logic                                         any_bb_accept_i,
  output logic [PC_WIDTH+CC_ID_BITS-1:0]               ovr_data_o,
  output logic                                         ovr_valid_o,
  input  logic                                         ovr_ready_i,
  output logic                                         done_o,
  output logic                                         match_o
);

  localparam int                     W_SLOTS  = 2**CC_ID_BITS;
  localparam logic [CC_ID_BITS:0]    OCC_FULL = (CC_ID_BITS+1)'(W_SLOTS);
  localparam logic [CC_ID_BITS:0]    OCC_ONE  = (CC_ID_BITS+1)'(1);
  localparam logic [CC_ID_BITS-1:0]  ID_ONE   = CC_ID_BITS'(1);

  typedef struct packed {
    logic [CHARACTER_WIDTH-1:0] ch;
    slot_flags_t                flags;
  } slot_t;

  // Registered state and its next-state values
  state_e                          state_q,     state_d;
  logic [CC_ID_BITS-1:0]           head_q,      head_d;
  logic [CC_ID_BITS-1:0]           tail_q,      tail_d;
  logic [CC_ID_BITS:0]             occ_q,       occ_d;
  slot_t [W_SLOTS-1:0]             slot_q,      slot_d;
  logic                            ovr_valid_q, ovr_valid_d;
  logic [PC_WIDTH+CC_ID_BITS-1:0]  ovr_data_q,  ovr_data_d;
  logic                            new_char_q,  new_char_d;
  logic                            done_q,      done_d;
  logic                            match_q,     match_d;

  // Combinational helpers
  slot_t                           w_head_slot;
  logic                            w_active;
  logic                            w_head_pending;
  logic                            w_retire;
  logic                            w_fill;

  assign w_head_slot    = slot_q[head_q];
  assign w_active       = (state_q == ST_RUN) || (state_q == ST_DRAIN);

  // An engine must never see a slot retire before its start PC was delivered.
  assign w_head_pending = ovr_valid_q && (ovr_data_q[PC_WIDTH +: CC_ID_BITS] == head_q);

  assign w_retire = w_active
                 && w_head_slot.flags.enable
                 && w_head_slot.flags.settled
                 && !elaborating_chars_i[head_q]
                 && !w_head_pending;

  // A full window may still accept when the head retires in the same cycle.
  assign in_ready_o = (state_q == ST_RUN)
                   && !any_bb_accept_i
                   && !ovr_valid_q
                   && ((occ_q < OCC_FULL) || w_retire);

  assign w_fill = in_valid_i && in_ready_o;

  // Next-state: FSM transitions, slot fill/retire, injection handshake
  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q;
    occ_d       = occ_q;
    slot_d      = slot_q;
    ovr_valid_d = ovr_valid_q;
    ovr_data_d  = ovr_data_q;
    match_d     = match_q;
    new_char_d  = 1'b0;
    done_d      = 1'b0;

    // Any slot that was live during this cycle counts as settled from now on.
    for (int i = 0; i < W_SLOTS; i++) begin
      if (slot_q[CC_ID_BITS'(i)].flags.enable) begin
        slot_d[CC_ID_BITS'(i)].flags.settled = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_RUN;
          head_d  = '0;
          tail_d  = '0;
          occ_d   = '0;
          match_d = 1'b0;
        end
      end

      ST_RUN, ST_DRAIN: begin
        if (any_bb_accept_i) begin
          // A match ends the string at once; the pending injection is dropped.
          match_d     = 1'b1;
          ovr_valid_d = 1'b0;
          occ_d       = '0;
          state_d     = ST_DONE;
          done_d      = 1'b1;
          for (int i = 0; i < W_SLOTS; i++) begin
            slot_d[CC_ID_BITS'(i)].flags = '0;
          end
        end else begin
          if (w_retire) begin
            slot_d[head_q].flags = '0;
            head_d     = head_q + ID_ONE;
            new_char_d = 1'b1;
            if (w_head_slot.flags.end_of_s) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end

          // Fill is applied after retire so a full window can reuse the slot.
          if (w_fill) begin
            slot_d[tail_q].ch             = in_char_i;
            slot_d[tail_q].flags.enable   = 1'b1;
            slot_d[tail_q].flags.end_of_s = in_last_i;
            slot_d[tail_q].flags.settled  = 1'b0;
            tail_d      = tail_q + ID_ONE;
            ovr_data_d  = {tail_q, START_PC};
            ovr_valid_d = 1'b1;
            if (in_last_i) begin
              state_d = ST_DRAIN;
            end
          end else if (ovr_valid_q && ovr_ready_i) begin
            ovr_valid_d = 1'b0;
          end

          if (w_fill && !w_retire) begin
            occ_d = occ_q + OCC_ONE;
          end else if (!w_fill && w_retire) begin
            occ_d = occ_q - OCC_ONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      occ_q       <= '0;
      slot_q      <= '0;
      ovr_valid_q <= 1'b0;
      ovr_data_q  <= '0;
      new_char_q  <= 1'b0;
      done_q      <= 1'b0;
      match_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      occ_q       <= occ_d;
      slot_q      <= slot_d;
      ovr_valid_q <= ovr_valid_d;
      ovr_data_q  <= ovr_data_d;
      new_char_q  <= new_char_d;
      done_q      <= done_d;
      match_q     <= match_d;
    end
  end

  generate
    for (genvar gi = 0; gi < W_SLOTS; gi++) begin : g_slot_out
      assign cur_window_o[gi*CHARACTER_WIDTH +: CHARACTER_WIDTH] = slot_q[gi].ch;
      assign cur_window_enable_o[gi]   = slot_q[gi].flags.enable;
      assign cur_window_end_of_s_o[gi] = slot_q[gi].flags.end_of_s;
    end
  endgenerate

  assign new_char_o  = new_char_q;
  assign done_o      = done_q;
  assign match_o     = match_q;
  assign ovr_valid_o = ovr_valid_q;
  assign ovr_data_o  = ovr_data_q;

endmodule : char_window_feeder
`default_nettype wire

// File: tb/tb_char_window_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_char_window_feeder                                        |
// | Description : Directed self-checking bench for char_window_feeder, W=2.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_char_window_feeder;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [7:0]  in_char_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        in_last_i;
  logic [15:0] cur_window_o;
  logic [1:0]  cur_window_enable_o;
  logic [1:0]  cur_window_end_of_s_o;
  logic        new_char_o;
  logic [1:0]  elaborating_chars_i;
  logic        any_bb_accept_i;
  logic [8:0]  ovr_data_o;
  logic        ovr_valid_o;
  logic        ovr_ready_i;
  logic        done_o;
  logic        match_o;

  int checks = 0;
  int errors = 0;
  int nc_count = 0;

  char_window_feeder #(
    .CHARACTER_WIDTH(8),
    .CC_ID_BITS     (1),
    .PC_WIDTH       (8),
    .START_PC       (8'h5A)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .start_i              (start_i),
    .in_char_i            (in_char_i),
    .in_valid_i           (in_valid_i),
    .in_ready_o           (in_ready_o),
    .in_last_i            (in_last_i),
    .cur_window_o         (cur_window_o),
    .cur_window_enable_o  (cur_window_enable_o),
    .cur_window_end_of_s_o(cur_window_end_of_s_o),
    .new_char_o           (new_char_o),
    .elaborating_chars_i  (elaborating_chars_i),
    .any_bb_accept_i      (any_bb_accept_i),
    .ovr_data_o           (ovr_data_o),
    .ovr_valid_o          (ovr_valid_o),
    .ovr_ready_i          (ovr_ready_i),
    .done_o               (done_o),
    .match_o              (match_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count new_char pulses away from the active edge.
  always @(negedge clk) if (new_char_o) nc_count++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Offers one character and returns one cycle after it was accepted.
  task automatic feed_char(input logic [7:0] ch, input logic last, output bit ok);
    in_char_i  = ch;
    in_last_i  = last;
    in_valid_i = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (in_ready_o) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) tick();
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
  endtask

  task automatic test_reset();
    logic [33:0] obs;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    obs = {cur_window_o, cur_window_enable_o, cur_window_end_of_s_o, new_char_o,
           ovr_data_o, ovr_valid_o, done_o, match_o, in_ready_o};
    checks++;
    if (obs !== 34'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", obs);
    end
  endtask

  task automatic test_stream_ab();
    elaborating_chars_i = 2'b00;
    ovr_ready_i = 1'b1;
    do_start();
    in_char_i = 8'h61; in_last_i = 1'b0; in_valid_i = 1'b1;
    #1;
    checks++;
    if (in_ready_o !== 1'b1) begin errors++; $display("FAIL ab_ready_t0: got %b expected 1", in_ready_o); end
    tick();  // t1: 'a' in slot 0
    in_char_i = 8'h62; in_last_i = 1'b1;
    #1;
    checks++;
    if ({cur_window_o[7:0], cur_window_enable_o, ovr_valid_o, ovr_data_o, in_ready_o} !== {8'h61, 2'b01, 1'b1, 9'h05A, 1'b0}) begin
      errors++;
      $display("FAIL ab_t1: got char=%h en=%b ov=%b od=%h rdy=%b expected char=61 en=01 ov=1 od=05a rdy=0",
               cur_window_o[7:0], cur_window_enable_o, ovr_valid_o, ovr_data_o, in_ready_o);
    end
    tick();  // t2: injection done, 'b' accepted while 'a' retires
    checks++;
    if ({ovr_valid_o, in_ready_o} !== 2'b01) begin
      errors++; $display("FAIL ab_t2: got ov=%b rdy=%b expected ov=0 rdy=1", ovr_valid_o, in_ready_o);
    end
    tick();  // t3
    in_valid_i = 1'b0; in_last_i = 1'b0;
    checks++;
    if ({cur_window_o[15:8], cur_window_enable_o, cur_window_end_of_s_o, new_char_o, ovr_valid_o, ovr_data_o}
        !== {8'h62, 2'b10, 2'b10, 1'b1, 1'b1, 9'h15A}) begin
      errors++;
      $display("FAIL ab_t3: got char=%h en=%b eos=%b nc=%b ov=%b od=%h expected char=62 en=10 eos=10 nc=1 ov=1 od=15a",
               cur_window_o[15:8], cur_window_enable_o, cur_window_end_of_s_o, new_char_o, ovr_valid_o, ovr_data_o);
    end
    tick();  // t4
    checks++;
    if ({new_char_o, done_o} !== 2'b00) begin
      errors++; $display("FAIL ab_t4: got nc=%b done=%b expected 0 0", new_char_o, done_o);
    end
    tick();  // t5: last slot retired
    checks++;
    if ({new_char_o, done_o, match_o, cur_window_enable_o} !== {1'b1, 1'b1, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL ab_t5: got nc=%b done=%b match=%b en=%b expected nc=1 done=1 match=0 en=00",
               new_char_o, done_o, match_o, cur_window_enable_o);
    end
    tick();  // t6: back in IDLE
    checks++;
    if (done_o !== 1'b0) begin errors++; $display("FAIL ab_t6_done: got %b expected 0", done_o); end
  endtask

  task automatic test_window_full();
    bit ok1, ok2, seen;
    elaborating_chars_i = 2'b01;
    ovr_ready_i = 1'b1;
    do_start();
    feed_char(8'h78, 1'b0, ok1);
    feed_char(8'h79, 1'b0, ok2);
    checks++;
    if ({ok1, ok2, cur_window_enable_o} !== 4'b1111) begin
      errors++; $display("FAIL full_fill: got ok=%b%b en=%b expected ok=11 en=11", ok1, ok2, cur_window_enable_o);
    end
    in_char_i = 8'h7A; in_last_i = 1'b1; in_valid_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      checks++;
      if ({in_ready_o, new_char_o} !== 2'b00) begin
        errors++; $display("FAIL full_hold_%0d: got rdy=%b nc=%b expected 0 0", k, in_ready_o, new_char_o);
      end
      tick();
    end
    elaborating_chars_i = 2'b00;
    #1;
    checks++;
    if (in_ready_o !== 1'b1) begin errors++; $display("FAIL full_release_ready: got %b expected 1", in_ready_o); end
    tick();
    in_valid_i = 1'b0; in_last_i = 1'b0;
    checks++;
    if ({new_char_o, cur_window_enable_o, cur_window_o[7:0], cur_window_end_of_s_o, ovr_data_o}
        !== {1'b1, 2'b11, 8'h7A, 2'b01, 9'h05A}) begin
      errors++;
      $display("FAIL full_retire: got nc=%b en=%b char=%h eos=%b od=%h expected nc=1 en=11 char=7a eos=01 od=05a",
               new_char_o, cur_window_enable_o, cur_window_o[7:0], cur_window_end_of_s_o, ovr_data_o);
    end
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (done_o) begin seen = 1'b1; break; end
      tick();
    end
    checks++;
    if ({seen, match_o} !== 2'b10) begin
      errors++; $display("FAIL full_done: got done_seen=%b match=%b expected 1 0", seen, match_o);
    end
    tick();
  endtask

  task automatic test_ovr_backpressure();
    bit ok, seen;
    elaborating_chars_i = 2'b00;
    ovr_ready_i = 1'b0;
    do_start();
    feed_char(8'h70, 1'b0, ok);
    in_char_i = 8'h71; in_last_i = 1'b1; in_valid_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if ({ok, ovr_valid_o, ovr_data_o, in_ready_o, cur_window_enable_o, new_char_o}
          !== {1'b1, 1'b1, 9'h05A, 1'b0, 2'b01, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold_%0d: got ok=%b ov=%b od=%h rdy=%b en=%b nc=%b expected 1 1 05a 0 01 0",
                 k, ok, ovr_valid_o, ovr_data_o, in_ready_o, cur_window_enable_o, new_char_o);
      end
      tick();
    end
    ovr_ready_i = 1'b1;
    #1;
    checks++;
    if ({ovr_valid_o, in_ready_o} !== 2'b10) begin
      errors++; $display("FAIL bp_handshake: got ov=%b rdy=%b expected 1 0", ovr_valid_o, in_ready_o);
    end
    tick();
    checks++;
    if ({ovr_valid_o, new_char_o, in_ready_o} !== 3'b001) begin
      errors++; $display("FAIL bp_after: got ov=%b nc=%b rdy=%b expected 0 0 1", ovr_valid_o, new_char_o, in_ready_o);
    end
    tick();
    in_valid_i = 1'b0; in_last_i = 1'b0;
    checks++;
    if ({new_char_o, cur_window_enable_o, cur_window_o[15:8], ovr_data_o} !== {1'b1, 2'b10, 8'h71, 9'h15A}) begin
      errors++;
      $display("FAIL bp_retire: got nc=%b en=%b char=%h od=%h expected nc=1 en=10 char=71 od=15a",
               new_char_o, cur_window_enable_o, cur_window_o[15:8], ovr_data_o);
    end
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (done_o) begin seen = 1'b1; break; end
      tick();
    end
    checks++;
    if ({seen, match_o} !== 2'b10) begin
      errors++; $display("FAIL bp_done: got done_seen=%b match=%b expected 1 0", seen, match_o);
    end
    tick();
  endtask

  task automatic test_accept();
    bit ok, seen;
    elaborating_chars_i = 2'b11;
    ovr_ready_i = 1'b0;
    do_start();
    feed_char(8'h6D, 1'b0, ok);
    any_bb_accept_i = 1'b1;
    #1;
    checks++;
    if ({ok, in_ready_o} !== 2'b10) begin
      errors++; $display("FAIL acc_ready: got ok=%b rdy=%b expected 1 0", ok, in_ready_o);
    end
    tick();
    any_bb_accept_i = 1'b0;
    checks++;
    if ({cur_window_enable_o, ovr_valid_o, done_o, match_o} !== 5'b00011) begin
      errors++;
      $display("FAIL acc_done: got en=%b ov=%b done=%b match=%b expected 00 0 1 1",
               cur_window_enable_o, ovr_valid_o, done_o, match_o);
    end
    tick();
    checks++;
    if ({done_o, match_o} !== 2'b01) begin
      errors++; $display("FAIL acc_after: got done=%b match=%b expected 0 1", done_o, match_o);
    end
    tick();
    tick();
    checks++;
    if (match_o !== 1'b1) begin errors++; $display("FAIL acc_idle_hold: got %b expected 1", match_o); end
    do_start();
    checks++;
    if (match_o !== 1'b0) begin errors++; $display("FAIL acc_start_clear: got %b expected 0", match_o); end
    elaborating_chars_i = 2'b00;
    ovr_ready_i = 1'b1;
    feed_char(8'h7A, 1'b1, ok);
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (done_o) begin seen = 1'b1; break; end
      tick();
    end
    checks++;
    if ({ok, seen, match_o} !== 3'b110) begin
      errors++; $display("FAIL acc_rerun: got ok=%b done_seen=%b match=%b expected 1 1 0", ok, seen, match_o);
    end
    tick();
  endtask

  task automatic test_wrap();
    bit ok, seen;
    int nc_start;
    logic [7:0] ch;
    elaborating_chars_i = 2'b00;
    ovr_ready_i = 1'b1;
    nc_start = nc_count;
    do_start();
    for (int i = 0; i < 7; i++) begin
      ch = 8'h41 + 8'(i);
      feed_char(ch, (i == 6), ok);
      checks++;
      if ({ok, cur_window_o[(i%2)*8 +: 8], cur_window_enable_o[i%2], ovr_data_o}
          !== {1'b1, ch, 1'b1, (i % 2 == 1) ? 9'h15A : 9'h05A}) begin
        errors++;
        $display("FAIL wrap_char_%0d: got ok=%b char=%h en=%b od=%h expected ok=1 char=%h en=1 od=%h",
                 i, ok, cur_window_o[(i%2)*8 +: 8], cur_window_enable_o[i%2], ovr_data_o,
                 ch, (i % 2 == 1) ? 9'h15A : 9'h05A);
      end
    end
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (done_o) begin seen = 1'b1; break; end
      tick();
    end
    tick();
    checks++;
    if ({seen, match_o} !== 2'b10 || (nc_count - nc_start) != 7) begin
      errors++;
      $display("FAIL wrap_done: got done_seen=%b match=%b new_chars=%0d expected 1 0 7",
               seen, match_o, nc_count - nc_start);
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok1, ok2, ok3, seen;
    logic [33:0] obs;
    elaborating_chars_i = 2'b11;
    ovr_ready_i = 1'b1;
    do_start();
    feed_char(8'h72, 1'b0, ok1);
    feed_char(8'h73, 1'b0, ok2);
    checks++;
    if ({ok1, ok2, cur_window_enable_o, ovr_valid_o} !== 5'b11111) begin
      errors++; $display("FAIL rstmid_fill: got ok=%b%b en=%b ov=%b expected 11 11 1",
                         ok1, ok2, cur_window_enable_o, ovr_valid_o);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    obs = {cur_window_o, cur_window_enable_o, cur_window_end_of_s_o, new_char_o,
           ovr_data_o, ovr_valid_o, done_o, match_o, in_ready_o};
    checks++;
    if (obs !== 34'h0) begin
      errors++; $display("FAIL rstmid_outputs: got %h expected 0", obs);
    end
    elaborating_chars_i = 2'b00;
    do_start();
    feed_char(8'h75, 1'b1, ok3);
    checks++;
    if ({ok3, cur_window_o[7:0], cur_window_enable_o, ovr_data_o} !== {1'b1, 8'h75, 2'b01, 9'h05A}) begin
      errors++;
      $display("FAIL rstmid_restart: got ok=%b char=%h en=%b od=%h expected 1 75 01 05a",
               ok3, cur_window_o[7:0], cur_window_enable_o, ovr_data_o);
    end
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (done_o) begin seen = 1'b1; break; end
      tick();
    end
    checks++;
    if ({seen, match_o} !== 2'b10) begin
      errors++; $display("FAIL rstmid_done: got done_seen=%b match=%b expected 1 0", seen, match_o);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    start_i = 1'b0;
    in_char_i = 8'h00;
    in_valid_i = 1'b0;
    in_last_i = 1'b0;
    elaborating_chars_i = 2'b00;
    any_bb_accept_i = 1'b0;
    ovr_ready_i = 1'b0;
    test_reset();
    test_stream_ab();
    test_window_full();
    test_ovr_backpressure();
    test_accept();
    test_wrap();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_char_window_feeder
`default_nettype wire

// File: doc/char_window_feeder.md
# char_window_feeder

Supplies the coprocessor topology with its sliding character window. Accepts the input string as a byte stream, places each character in one of 2**CC_ID_BITS circular slots (slot index = CC id), and injects a start PC for each new character on the topology's override channel. Retires the oldest character once no engine is elaborating it. Reports string completion and match to the controller.

## Interface
- CHARACTER_WIDTH, 8, character width
- CC_ID_BITS, 1, log2 of window slots W
- PC_WIDTH, 8, PC width
- START_PC, 0, PC injected for every new character
---
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a string; ignored unless IDLE
- in_char  in  CHARACTER_WIDTH  stream character
- in_valid / in_ready  in / out  1  stream handshake
- in_last  in  1  qualifies the final character of the string
- cur_window  out  W*CHARACTER_WIDTH  slot i at bits [i*CW +: CW]
- cur_window_enable  out  W  slot holds a live character
- cur_window_end_of_s  out  W  slot holds the last character
- new_char  out  1  one-cycle pulse on every retire
- elaborating_chars  in  W  engines still using slot i
- any_bb_accept  in  1  a thread reached accept
- ovr_data  out  PC_WIDTH+CC_ID_BITS  {cc_id, START_PC}, cc_id in MSBs
- ovr_valid / ovr_ready  out / in  1  override handshake
- done  out  1  one-cycle pulse at end of string
- match  out  1  result, held until next start

## Operation
- FSM: IDLE -> RUN on start. RUN -> DRAIN when a character with in_last=1 is accepted. DRAIN -> DONE when the end_of_s slot retires. RUN/DRAIN -> DONE on any_bb_accept. DONE -> IDLE after 1 cycle.
- Pointers head and tail, each CC_ID_BITS wide, wrap modulo W. Occupancy counter is CC_ID_BITS+1 wide.
- Fill: in_ready = (state==RUN) && occupancy<W && !ovr_valid. On handshake:
  - write slot[tail] and set enable[tail];
  - set end_of_s[tail] if in_last;
  - tail++;
  - load ovr_data={tail,START_PC}, ovr_valid=1.
- ovr_valid holds with stable data until ovr_ready, then drops. At most one injection is outstanding.
- Retire conditions: enable[head]=1, elaborating_chars[head]=0, slot live for at least 1 full cycle (per-slot settle bit), and no pending injection targeting head. On retire:
  - clear enable[head] and end_of_s[head];
  - head++;
  - pulse new_char the next cycle.
- Retire and fill in the same cycle are both allowed. Occupancy is unchanged, and tail may equal the retired index.
- any_bb_accept in RUN/DRAIN: match=1, clear all enables, drop in_ready, drop ovr_valid (pending injection abandoned), go to DONE. Stream characters not yet consumed are the upstream's responsibility.
- DONE: done=1 for one cycle. match=0 if entered via drain.
- start clears match and both pointers.

## Timing
- Reset values: state IDLE, all outputs 0 (including in_ready, ovr_valid, new_char, done, match), pointers 0.
- All outputs are registered except in_ready, which is combinational from state, occupancy and ovr_valid.
- Character accepted at cycle t:
  - enable and data visible at t+1;
  - ovr_valid asserted at t+1;
  - earliest retire at t+2, new_char at t+3.
- Full window (occupancy=W): in_ready=0. It rises the cycle after a retire, or combinationally in the retire cycle via the simultaneous retire/fill rule.
- Empty window in RUN: no retire, no new_char.
- Reset mid-operation clears everything within 1 cycle. There is no outstanding-handshake recovery.

## Structure
- Package cicero_window_pkg: state enum (IDLE, RUN, DRAIN, DONE) and a slot_t struct {char, enable, end_of_s, settled}.
- No sub-module required. Optionally add window_slot_ring as the per-slot register array with pointer logic.

## Test plan
- W=2. Stream "ab" (in_last on 'b'), elaborating_chars=0, ovr_ready=1:
  - slots 0='a' and 1='b';
  - ovr_data {0,START_PC} then {1,START_PC};
  - two new_char pulses;
  - done pulse with match=0.
- Window full, elaborating_chars[0] held 1 for 10 cycles: in_ready=0 and no new_char for those 10 cycles; retire of slot 0 occurs 1 cycle after release.
- ovr_ready=0 for 5 cycles: ovr_valid and data stable, in_ready=0, head slot not retired until the handshake.
- any_bb_accept mid-string: next cycle enables=0 and ovr_valid=0; done pulse with match=1; match held through IDLE until next start.
- Wrap-around: 7-character string with W=2. Pointers wrap 3 times, and each character appears in slot (index mod 2).
- rst asserted in RUN with occupancy 2: all outputs 0 next cycle; a subsequent start works normally.
